fetch_ctrl: RTL

Instruction-fetch sequencer for the IF stage. Owns the program counter, issues one instruction-memory request at a time, and buffers the returned word for decode. Handles branch/jump redirects from later stages, including discarding in-flight stale responses. Sits between the instruction memory port and the ID stage.

---
 rtl/fetch_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one imem transaction in flight and holds one word for decode.
// Optional FETCH_CNT_EN adds fetch_cnt_o, a count of decode handshakes.
module fetch_ctrl #(
  parameter int ADDR = 16,
  parameter int WORD = 32,
  parameter logic [ADDR:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [ADDR:0]   redirect_pc_i,
  output logic            imem_req_o,
  output logic [ADDR:0]   imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [WORD-1:0] imem_rdata_i,
  output logic            id_valid_o,
  output logic [WORD-1:0] id_instr_o,
  output logic [ADDR:0]   id_pc_o,
  input  logic            id_ready_i,
  output logic [ADDR:0]   pc_o
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]     fetch_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  localparam logic [ADDR:0] PC_STEP = (ADDR+1)'(4);

  state_t        state;
  logic [ADDR:0] pc;
  logic [ADDR:0] req_pc;
  logic          buf_free;
  logic [ADDR:0] redir_tgt;

  assign buf_free    = !id_valid_o || id_ready_i;
  assign redir_tgt   = {redirect_pc_i[ADDR:2], 2'b00};
  assign imem_addr_o = pc;
  assign pc_o        = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      req_pc     <= '0;
      imem_req_o <= 1'b0;
      id_valid_o <= 1'b0;
      id_instr_o <= '0;
      id_pc_o    <= '0;
    end else begin
      imem_req_o <= 1'b0;
      if (redirect_i) begin
        // A granted or outstanding request still owes us one response; DROP absorbs it.
        pc         <= redir_tgt;
        id_valid_o <= 1'b0;
        case (state)
          S_REQ:   state <= imem_gnt_i ? S_DROP : S_IDLE;
          S_WAIT:  state <= imem_rvalid_i ? S_IDLE : S_DROP;
          S_DROP:  state <= imem_rvalid_i ? S_IDLE : S_DROP;
          default: state <= S_IDLE;
        endcase
      end else begin
        if (id_valid_o && id_ready_i)
          id_valid_o <= 1'b0;
        case (state)
          S_IDLE: begin
            if (buf_free) begin
              state      <= S_REQ;
              imem_req_o <= 1'b1;
            end
          end
          S_REQ: begin
            if (imem_gnt_i) begin
              req_pc <= pc;
              pc     <= pc + PC_STEP;
              state  <= S_WAIT;
            end else begin
              imem_req_o <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rvalid_i) begin
              id_valid_o <= 1'b1;
              id_instr_o <= imem_rdata_i;
              id_pc_o    <= req_pc;
              state      <= S_IDLE;
            end
          end
          S_DROP: begin
            if (imem_rvalid_i)
              state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef FETCH_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      fetch_cnt_o <= '0;
    else if (id_valid_o && id_ready_i)
      fetch_cnt_o <= fetch_cnt_o + 32'd1;
  end
`endif

endmodule
